// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx
//   Pops words from the team's synchronous FIFO and shifts each one out
//   LSB-first as a frame: start bit (0), DATA_WIDTH data bits, stop bit (1).
//   The FIFO has a registered data_out, so the word appears one cycle after
//   the rd_en pulse. That is why FETCH and LOAD are separate states.
//
//   State table:
//     state | meaning
//     IDLE  | line high; waits for enable && !fifo_empty
//     FETCH | one-cycle fifo_rd_en pulse
//     LOAD  | fifo_data valid; captured into shift register, tx driven low
//     START | start bit (0) held CLKS_PER_BIT cycles
//     DATA  | DATA_WIDTH data bits, LSB first, CLKS_PER_BIT cycles each
//     STOP  | stop bit (1); frame_done in its last cycle
//
// Ports
//   clk         in   clock, all state updates on posedge
//   rst_n       in   synchronous active-low reset
//   enable      in   allows a new frame to start (sampled in IDLE only)
//   fifo_empty  in   FIFO empty flag
//   fifo_rd_en  out  FIFO read strobe, one pulse per word
//   fifo_data   in   FIFO data_out, valid the cycle after rd_en
//   tx          out  registered serial line, idles high
//   busy        out  high whenever not in IDLE
//   frame_done  out  pulse in the last cycle of the stop bit
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 6,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                  state, state_nxt;
    logic                    tx_r, tx_nxt;
    logic [BAUD_W-1:0]       baud_cnt, baud_nxt;
    logic [IDX_W-1:0]        bit_idx, bit_nxt;
    logic [DATA_WIDTH-1:0]   shift, shift_nxt;
    logic                    baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign tx       = tx_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            tx_r     <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            state    <= state_nxt;
            tx_r     <= tx_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        tx_nxt     = tx_r;
        baud_nxt   = baud_cnt;
        bit_nxt    = bit_idx;
        shift_nxt  = shift;
        fifo_rd_en = 1'b0;
        busy       = (state != S_IDLE);
        frame_done = 1'b0;

        case (state)
            S_IDLE: begin
                tx_nxt   = 1'b1;
                baud_nxt = '0;
                bit_nxt  = '0;
                if (enable && !fifo_empty) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                fifo_rd_en = 1'b1;
                state_nxt  = S_LOAD;
            end
            S_LOAD: begin
                shift_nxt = fifo_data;
                tx_nxt    = 1'b0;
                baud_nxt  = '0;
                state_nxt = S_START;
            end
            S_START: begin
                if (baud_end) begin
                    // Present bit 0 and pre-shift so shift[0] is always the next bit.
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    tx_nxt    = shift[0];
                    shift_nxt = shift >> 1;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_idx == IDX_LAST) begin
                        tx_nxt    = 1'b1;
                        state_nxt = S_STOP;
                    end else begin
                        bit_nxt   = bit_idx + 1'b1;
                        tx_nxt    = shift[0];
                        shift_nxt = shift >> 1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    frame_done = 1'b1;
                    baud_nxt   = '0;
                    state_nxt  = S_IDLE;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
module tb_fifo_serial_tx;

    localparam int DW     = 6;
    localparam int CPB    = 4;
    localparam int FR_LEN = (DW + 2) * CPB;
    // Model transaction time t: 0 = FETCH, 1 = LOAD, 2..FR_LEN+1 = line frame
    localparam int T_LAST = FR_LEN + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_data = '0;
    logic          tx;
    logic          busy;
    logic          frame_done;

    fifo_serial_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .fifo_data  (fifo_data),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int rd_cnt  = 0;
    bit chk_en  = 1'b0;

    logic [DW-1:0] q[$];
    bit            m_active = 1'b0;
    int            m_t = 0;
    logic [DW-1:0] m_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    task automatic push(input logic [DW-1:0] w);
        q.push_back(w);
    endtask

    // FIFO model (registered data_out) plus the transaction-level predictor.
    always @(posedge clk) begin
        if (fifo_rd_en) rd_cnt++;
        if (!rst_n) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (!m_active) begin
            if (enable && !fifo_empty) begin
                m_active = 1'b1;
                m_t      = 0;
                m_word   = q[0];
            end
        end else if (m_t == T_LAST) begin
            m_active = 1'b0;
        end else begin
            m_t++;
        end
        if (fifo_rd_en && q.size() > 0) fifo_data <= q.pop_front();
    end

    always @(negedge clk) fifo_empty <= (q.size() == 0);

    // Per-cycle compare against the predictor.
    always @(negedge clk) begin : cmp
        logic e_tx;
        int   b;
        if (chk_en) begin
            e_tx = 1'b1;
            if (m_active && m_t >= 2) begin
                b = (m_t - 2) / CPB;
                if (b == 0)       e_tx = 1'b0;
                else if (b <= DW) e_tx = m_word[b-1];
            end
            check("tx", 32'(tx), 32'(e_tx));
            check("busy", 32'(busy), 32'(m_active));
            check("rd_en", 32'(fifo_rd_en), 32'(m_active && m_t == 0));
            check("frame_done", 32'(frame_done), 32'(m_active && m_t == T_LAST));
        end
    end

    task automatic wait_tx_low(input string name);
        int w = 0;
        while (tx !== 1'b0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        if (tx !== 1'b0) timeout_fail(name);
    endtask

    task automatic wait_done(input string name);
        int w = 0;
        while (frame_done !== 1'b1 && w < 80) begin
            @(negedge clk);
            w++;
        end
        if (frame_done !== 1'b1) timeout_fail(name);
    endtask

    // Records tx and frame_done for the 32 line cycles starting at the start bit.
    task automatic capture(input string name, output logic [31:0] txv, output logic [31:0] dv);
        txv = '1;
        dv  = '0;
        wait_tx_low(name);
        if (tx === 1'b0) begin
            for (int i = 0; i < FR_LEN; i++) begin
                txv[i] = tx;
                dv[i]  = frame_done;
                if (i < FR_LEN - 1) @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] txv, dv;
        int r0, gap;

        rst_n  = 1'b0;
        enable = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
            check("rst_frame_done", 32'(frame_done), 32'd0);
            @(negedge clk);
        end
        rst_n = 1'b1;

        // Empty FIFO with enable high: nothing happens
        enable = 1'b1;
        r0 = rd_cnt;
        repeat (20) @(negedge clk);
        check("empty_rd_cnt", 32'(rd_cnt - r0), 32'd0);
        check("empty_tx", 32'(tx), 32'd1);
        check("empty_busy", 32'(busy), 32'd0);

        // Data waiting but enable low: nothing happens
        enable = 1'b0;
        push(6'b101101);
        r0 = rd_cnt;
        repeat (20) @(negedge clk);
        check("disabled_rd_cnt", 32'(rd_cnt - r0), 32'd0);
        check("disabled_busy", 32'(busy), 32'd0);

        // Single word 101101
        enable = 1'b1;
        capture("single_start", txv, dv);
        check("single_tx_bits", txv, 32'hFF0FF0F0);
        check("single_done_pos", dv, 32'h8000_0000);
        repeat (5) @(negedge clk);
        check("single_rd_cnt", 32'(rd_cnt - r0), 32'd1);
        check("single_fifo_drained", 32'(q.size()), 32'd0);

        // Two queued words, back to back
        r0 = rd_cnt;
        push(6'h3F);
        push(6'h00);
        wait_done("pair_first_done");
        gap = 0;
        @(negedge clk);
        while (tx !== 1'b0 && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        check("pair_gap_high_cycles", 32'(gap), 32'd3);
        repeat (40) @(negedge clk);
        check("pair_rd_cnt", 32'(rd_cnt - r0), 32'd2);
        check("pair_busy_after", 32'(busy), 32'd0);

        // Drop enable during a data bit: frame completes, no further pops
        r0 = rd_cnt;
        push(6'h15);
        push(6'h2A);
        wait_tx_low("drop_start");
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (60) @(negedge clk);
        check("drop_rd_cnt", 32'(rd_cnt - r0), 32'd1);
        check("drop_fifo_left", 32'(q.size()), 32'd1);
        check("drop_busy", 32'(busy), 32'd0);

        // Reset during data bit 3 of 0x2A, then a fresh frame of 0x0B
        enable = 1'b1;
        wait_tx_low("rst_frame_start");
        repeat (16) @(negedge clk);
        check("rst_bit3_tx", 32'(tx), 32'd1);
        check("rst_bit3_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        push(6'h0B);
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        r0 = rd_cnt;
        rst_n = 1'b1;
        capture("after_rst_start", txv, dv);
        check("after_rst_tx_bits", txv, 32'hF00F0FF0);
        check("after_rst_done_pos", dv, 32'h8000_0000);
        repeat (10) @(negedge clk);
        check("after_rst_rd_cnt", 32'(rd_cnt - r0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
